sa_grant_scheduler: RTL and testbench

SA_GRANT_SCHEDULER -- requirements
Module: sa_grant_scheduler

---
 rtl/sa_sched_pkg.sv | 14 +
 rtl/sa_rr_pick.sv | 36 +++
 rtl/sa_grant_scheduler.sv | 110 +++++++++++
 tb/tb_sa_grant_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_sched_pkg.sv
// Shared types and default sizing for the grant scheduler.
// The state enum and the requester/hold defaults live here.
package sa_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int N_REQ_DEF    = 5;
    localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/sa_rr_pick.sv
// Round-robin priority search: first set req bit at or after ptr,
// wrapping from N_REQ-1 back to 0.
module sa_rr_pick #(
    parameter int N_REQ = 5,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    idx,
    output logic             any
);

    logic [PW:0] pos;

    // Scan offsets from far to near so the nearest hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (PW + 1)'(k);
            if (pos >= (PW + 1)'(N_REQ)) begin
                pos = pos - (PW + 1)'(N_REQ);
            end
            if (req[pos[PW-1:0]]) begin
                onehot              = '0;
                onehot[pos[PW-1:0]] = 1'b1;
                idx                 = pos[PW-1:0];
                any                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_grant_scheduler.sv
// Round-robin resource scheduler with a bounded hold time.
// A grant ends on done or when the hold limit reclaims it.
module sa_grant_scheduler
    import sa_sched_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [PW-1:0] ID_LAST   = PW'(N_REQ - 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]    id_q, id_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic [PW-1:0]    next_ptr;

    sa_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign next_ptr = (id_q == ID_LAST) ? '0 : id_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick_onehot;
                    id_d    = pick_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                // done takes priority over the hold limit.
                if (done || hold_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    ptr_d     = next_ptr;
                    timeout_d = !done;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                hold_d  = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            id_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = 3'(id_q);
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sa_grant_scheduler.sv
// Bench for sa_grant_scheduler: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_sa_grant_scheduler;

    localparam int N   = 5;
    localparam int MAX = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_id;
    logic         gnt_valid;
    logic         timeout;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: current owner (-1 none), cycles visible, gap flag, pointer.
    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_ptr   = 0;
    int m_to    = 0;

    sa_grant_scheduler #(
        .N_REQ    (N),
        .MAX_HOLD (MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_ptr   = 0;
        m_to    = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            m_to = 0;
            if (m_owner >= 0) begin
                if (done || m_held == MAX) begin
                    m_to    = done ? 0 : 1;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_gap   = 1;
                end else begin
                    m_held++;
                end
            end else if (m_gap != 0) begin
                m_gap = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (m_owner < 0 && req[j]) begin
                        m_owner = j;
                        m_held  = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        check("gnt", 32'(gnt), 32'(eg));
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        if (m_owner >= 0) check("gnt_id", 32'(gnt_id), 32'(m_owner));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        done = 1'b0;
        req  = '0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_id", 32'(gnt_id), 32'd0);
        check("rst_vld", 32'(gnt_valid), 32'd0);
        check("rst_to", 32'(timeout), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag, output int id);
        int n;
        n = 0;
        while (!gnt_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 32'(gnt_valid), 32'd1);
        id = gnt_valid ? int'(gnt_id) : -1;
    endtask

    initial begin
        int id;
        int vcnt;
        int tcnt;
        int exp_order[6];
        exp_order = '{0, 1, 2, 3, 4, 0};

        @(posedge clk);
        #1;
        do_reset();

        // Test 1
        req = 5'b00101;
        tick();
        check("t1_gnt0", 32'(gnt), 32'b00001);
        check("t1_id0", 32'(gnt_id), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t1_rel", 32'(gnt), 32'd0);
        tick();
        tick();
        check("t1_gnt2", 32'(gnt), 32'b00100);
        check("t1_id2", 32'(gnt_id), 32'd2);

        // Test 2: full request, done on 3rd grant cycle
        do_reset();
        req = 5'b11111;
        for (int g = 0; g < 6; g++) begin
            wait_grant("t2", id);
            check($sformatf("t2_order%0d", g), 32'(id), 32'(exp_order[g]));
            tick();
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end

        // Test 3: hold limit on requester 3
        do_reset();
        req = 5'b01000;
        wait_grant("t3", id);
        vcnt = 0;
        tcnt = 0;
        for (int c = 0; c < 40 && tcnt == 0; c++) begin
            if (gnt_valid && gnt_id == 3'd3) vcnt++;
            tick();
            if (timeout) tcnt++;
        end
        check("t3_hold", 32'(vcnt), 32'(MAX));
        check("t3_to_gnt", 32'(gnt), 32'd0);
        req = 5'b11000;
        tick();
        check("t3_to_once", 32'(timeout), 32'd0);
        wait_grant("t3b", id);
        check("t3_next", 32'(id), 32'd4);

        // Test 4: done on the last hold cycle wins over timeout
        do_reset();
        req = 5'b00010;
        wait_grant("t4", id);
        for (int c = 0; c < MAX - 1; c++) tick();
        check("t4_still", 32'(gnt), 32'b00010);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t4_rel", 32'(gnt), 32'd0);
        check("t4_no_to", 32'(timeout), 32'd0);

        // Test 5: reset mid-grant
        do_reset();
        req = 5'b00100;
        wait_grant("t5", id);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        #1;
        check("t5_async", 32'(gnt), 32'd0);
        check("t5_no_to", 32'(timeout), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        req = 5'b10000;
        wait_grant("t5b", id);
        check("t5_id4", 32'(id), 32'd4);
        do_reset();
        req = 5'b10001;
        wait_grant("t5c", id);
        check("t5_ptr0", 32'(id), 32'd0);

        // Test 6: req drop mid-grant, done ignored in IDLE/RELEASE
        do_reset();
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        req = 5'b00010;
        wait_grant("t6", id);
        req = '0;
        for (int c = 0; c < 3; c++) tick();
        check("t6_held", 32'(gnt), 32'b00010);
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        tick();
        check("t6_idle", 32'(gnt), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req  = N'($urandom);
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst  = 1'b0;
        done = 1'b0;
        req  = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
